// File: rtl/prog_datapath_sequencer.sv
// rtl/prog_datapath_sequencer.sv - table-driven datapath control sequencer
// Replays a writable step table onto the datapath control outputs, either free-running or single-stepped.
module prog_datapath_sequencer #(
    parameter  int NUM_REGS = 5,
    parameter  int OP_W     = 4,
    parameter  int DEPTH    = 16,
    localparam int STEP_W   = $clog2(DEPTH),
    localparam int CW_W     = 9 + NUM_REGS + OP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic                Mode,
    input  logic                Step,
    input  logic                Abort,
    input  logic [STEP_W:0]     prog_len,
    input  logic                prog_we,
    input  logic [STEP_W-1:0]   prog_addr,
    input  logic [CW_W-1:0]     prog_wdata,
    output logic                In,
    output logic [1:0]          Bus2,
    output logic                AU1B3,
    output logic                AU1B4,
    output logic [1:0]          Bus5,
    output logic [1:0]          Bus7,
    output logic [NUM_REGS-1:0] LR,
    output logic [OP_W-1:0]     OP,
    output logic                BUSY,
    output logic                DONE,
    output logic                ABORTED,
    output logic [STEP_W-1:0]   step_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_FIN} state_t;

    localparam logic [STEP_W:0] MAX_LEN = (STEP_W + 1)'(DEPTH);

    state_t            state_r, state_n;
    logic [STEP_W:0]   len_r, len_n, eff_len, nxt_pos;
    logic [STEP_W-1:0] idx_r, idx_n;
    logic [CW_W-1:0]   cw_r, cw_n, word0;
    logic [CW_W-1:0]   mem [DEPTH];
    logic              busy_r, busy_n, done_r, done_n, ab_r, ab_n, wr_ok;

    // A write in the Start cycle is forwarded so the run sees the new entry 0.
    assign wr_ok   = prog_we & ~busy_r;
    assign word0   = (wr_ok && prog_addr == '0) ? prog_wdata : mem[0];
    assign eff_len = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign nxt_pos = {1'b0, idx_r} + (STEP_W + 1)'(1);

    always_comb begin
        state_n = state_r;
        len_n   = len_r;
        idx_n   = '0;
        cw_n    = '0;
        done_n  = 1'b0;
        ab_n    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (Start && !Abort) begin
                    len_n = eff_len;
                    if (eff_len == '0) begin
                        state_n = S_FIN;
                        done_n  = 1'b1;
                    end else begin
                        state_n = Mode ? S_WAIT : S_RUN;
                        cw_n    = word0;
                    end
                end
            end
            S_RUN, S_WAIT: begin
                if (Abort) begin
                    state_n = S_IDLE;
                    ab_n    = 1'b1;
                end else if (state_r == S_RUN || Step) begin
                    if (nxt_pos == len_r) begin
                        state_n = S_FIN;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = nxt_pos[STEP_W-1:0];
                        cw_n  = mem[nxt_pos[STEP_W-1:0]];
                    end
                end else begin
                    idx_n = idx_r;
                    cw_n  = cw_r;
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n == S_RUN) || (state_n == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            len_r   <= '0;
            idx_r   <= '0;
            cw_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ab_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            len_r   <= len_n;
            idx_r   <= idx_n;
            cw_r    <= cw_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            ab_r    <= ab_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    assign {In, Bus2, AU1B3, AU1B4, Bus7, Bus5, LR, OP} = cw_r;
    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign ABORTED  = ab_r;
    assign step_idx = idx_r;

endmodule

// File: tb/tb_prog_datapath_sequencer.sv
// tb/tb_prog_datapath_sequencer.sv - randomized self-checking bench for prog_datapath_sequencer
module tb_prog_datapath_sequencer;

    localparam int NUM_REGS = 5;
    localparam int OP_W     = 4;
    localparam int DEPTH    = 16;
    localparam int STEP_W   = $clog2(DEPTH);
    localparam int CW_W     = 9 + NUM_REGS + OP_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                Start = 1'b0, Mode = 1'b0, Step = 1'b0, Abort = 1'b0;
    logic [STEP_W:0]     prog_len = '0;
    logic                prog_we = 1'b0;
    logic [STEP_W-1:0]   prog_addr = '0;
    logic [CW_W-1:0]     prog_wdata = '0;
    logic                In, AU1B3, AU1B4, BUSY, DONE, ABORTED;
    logic [1:0]          Bus2, Bus5, Bus7;
    logic [NUM_REGS-1:0] LR;
    logic [OP_W-1:0]     OP;
    logic [STEP_W-1:0]   step_idx;

    logic [CW_W-1:0] tbl [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    prog_datapath_sequencer #(.NUM_REGS(NUM_REGS), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Mode(Mode), .Step(Step), .Abort(Abort),
        .prog_len(prog_len), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .In(In), .Bus2(Bus2), .AU1B3(AU1B3), .AU1B4(AU1B4), .Bus5(Bus5), .Bus7(Bus7),
        .LR(LR), .OP(OP), .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [CW_W-1:0] ecw, input int eidx,
                             input bit eb, input bit ed, input bit ea);
        check({tag, ".cw"}, 32'({In, Bus2, AU1B3, AU1B4, Bus7, Bus5, LR, OP}), 32'(ecw));
        check({tag, ".idx"}, 32'(step_idx), 32'(eidx));
        check({tag, ".flags"}, {29'd0, BUSY, DONE, ABORTED}, {29'd0, eb, ed, ea});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [CW_W-1:0] d);
        prog_we = 1'b1; prog_addr = STEP_W'(a); prog_wdata = d;
        tick();
        prog_we = 1'b0;
        tbl[a] = d;
        check_out("wr_idle", '0, 0, 0, 0, 0);
    endtask

    // Expected trace is built from the run rules: each of the first min(len,DEPTH) words
    // shows for 1 cycle (free-run) or until Step, then DONE, or an ABORTED pulse.
    task automatic run(input bit md, input int plen, input int abort_at, input int hold_fix,
                       input bit wr0, input logic [CW_W-1:0] w0);
        int  L, holds;
        bit  ab;
        L = (plen > DEPTH) ? DEPTH : plen;
        Mode = md; prog_len = (STEP_W + 1)'(plen); Start = 1'b1;
        if (wr0) begin
            prog_we = 1'b1; prog_addr = '0; prog_wdata = w0; tbl[0] = w0;
        end
        tick();
        Start = 1'b0; prog_we = 1'b0;
        Mode = 1'($urandom); prog_len = (STEP_W + 1)'($urandom);
        if (L == 0) begin
            check_out("len0", '0, 0, 0, 1, 0);
            tick();
            check_out("len0_idle", '0, 0, 0, 0, 0);
            return;
        end
        ab = 1'b0;
        for (int i = 0; i < L && !ab; i++) begin
            holds = md ? ((hold_fix >= 0) ? hold_fix : int'($urandom_range(0, 3))) : 0;
            for (int h = 0; h <= holds; h++) begin
                check_out("word", tbl[i], i, 1, 0, 0);
                Start      = 1'($urandom);
                prog_we    = 1'($urandom);
                prog_addr  = STEP_W'($urandom);
                prog_wdata = CW_W'($urandom);
                Step       = md ? (h == holds) : 1'($urandom);
                if (i == abort_at && h == holds) begin
                    Abort = 1'b1; Step = 1'($urandom); ab = 1'b1;
                end
                tick();
                Start = 1'b0; Step = 1'b0; Abort = 1'b0; prog_we = 1'b0;
            end
        end
        if (ab) begin
            check_out("abort", '0, 0, 0, 0, 1);
        end else begin
            check_out("done", '0, 0, 0, 1, 0);
            Start = 1'($urandom);
        end
        tick();
        Start = 1'b0;
        check_out("after", '0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
        rst = 1'b1;
        tick(); tick();
        check_out("reset", '0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        wr(0, 18'h20010); wr(1, 18'h00021); wr(2, 18'h3FFFF);
        run(0, 3, -1, -1, 0, '0);
        run(1, 3, -1, 5, 0, '0);
        run(0, 16, 4, -1, 0, '0);
        run(0, 16, -1, -1, 0, '0);
        run(0, 0, -1, -1, 0, '0);
        run(0, 17, -1, -1, 0, '0);
        run(0, 3, -1, -1, 1, CW_W'($urandom));

        Start = 1'b1; Abort = 1'b1;
        tick();
        Start = 1'b0; Abort = 1'b0;
        check_out("start_abort", '0, 0, 0, 0, 0);
        tick();
        check_out("start_abort2", '0, 0, 0, 0, 0);

        for (int i = 0; i < DEPTH; i++) wr(i, CW_W'($urandom));
        for (int r = 0; r < 40; r++) begin
            run(1'($urandom), int'($urandom_range(0, 20)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                -1, 1'($urandom), CW_W'($urandom));
        end

        Mode = 1'b0; prog_len = (STEP_W + 1)'(8); Start = 1'b1;
        tick();
        Start = 1'b0;
        check_out("rmid0", tbl[0], 0, 1, 0, 0);
        tick();
        check_out("rmid1", tbl[1], 1, 1, 0, 0);
        tick();
        check_out("rmid2", tbl[2], 2, 1, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out("rst_mid", '0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
        tick();
        check_out("rst_idle", '0, 0, 0, 0, 0);
        run(0, 4, -1, -1, 0, '0);
        run(1, 16, -1, -1, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_datapath_sequencer.md
Name: prog_datapath_sequencer

Overview:
Parametrised, programmable successor to the fixed-sequence datapath controller. Control words for the shared datapath (input mux, bus selects, ALU port enables, register load enables, ALU opcode) are held in a writable step table rather than hard-wired states. Each run replays a programmable number of steps. Supports free-run and single-step modes, abort, and a Start/BUSY/DONE handshake. Drives the same datapath control signals as the current controller, at generic register-file and opcode widths.

Parameters:
NUM_REGS, 5, number of datapath registers; width of LR one-hot load enables
OP_W, 4, ALU opcode width
DEPTH, 16, step-table entries (power of 2, >=2)
STEP_W, $clog2(DEPTH), step index width (localparam)
CW_W, 9+NUM_REGS+OP_W, control-word width (localparam; 18 at defaults)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
Start  in  1  begin run; sampled in IDLE only
Mode  in  1  0 = free-run, 1 = single-step; latched with Start
Step  in  1  advance one step in single-step mode
Abort  in  1  terminate run
prog_len  in  STEP_W+1  number of steps per run; latched with Start
prog_we  in  1  step-table write strobe
prog_addr  in  STEP_W  step-table write address
prog_wdata  in  CW_W  control word; MSB->LSB: In, Bus2[1:0], AU1B3, AU1B4, Bus7[1:0], Bus5[1:0], LR, OP
In  out  1  input-mux select
Bus2  out  2  bus-2 source select
AU1B3  out  1  ALU port enable B3
AU1B4  out  1  ALU port enable B4
Bus5  out  2  bus-5 source select
Bus7  out  2  bus-7 source select
LR  out  NUM_REGS  register load enables
OP  out  OP_W  ALU opcode
BUSY  out  1  high in RUN/WAIT
DONE  out  1  one-cycle completion pulse
ABORTED  out  1  one-cycle abort pulse
step_idx  out  STEP_W  index of the word currently driven

Behaviour:
- Reset: single clock `clk`; synchronous, active-high `rst`. rst wins over all other inputs. State=IDLE, all outputs 0, step table cleared to 0, latched len/mode cleared.
- All outputs registered. In IDLE/DONE every control output is 0.
- States: IDLE, RUN, WAIT, FIN.
- IDLE -> RUN on Start=1 & Abort=0; latch len=min(prog_len, DEPTH) and mode.
  - If len=0, go IDLE -> FIN directly (DONE pulses, no control word driven).
- Free-run timing: Start sampled at edge of cycle N; word[i] appears on the outputs in cycle N+1+i, i=0..len-1, with step_idx=i. In cycle N+len+1 the block is in FIN: DONE=1, outputs 0, BUSY=0. Next cycle returns to IDLE.
- Single-step (mode=1):
  - word[0] is driven in cycle N+1; state enters WAIT and holds the word.
  - Step sampled high advances to the next word in the following cycle.
  - Step sampled while the last word is driven -> FIN next cycle.
  - The Step input is ignored outside WAIT.
- Abort sampled high in RUN or WAIT: next cycle outputs are 0, ABORTED=1 for 1 cycle, DONE stays 0, state goes to IDLE.
- Simultaneous events:
  - Abort and Step together: Abort wins.
  - Abort and Start together in IDLE: no run, ABORTED stays 0.
- Start is ignored while BUSY or in FIN.
- Table writes:
  - Accepted only when BUSY=0 (IDLE/FIN); ignored while BUSY.
  - A write and Start in the same IDLE cycle: the write lands first, and the run uses the updated entry.
- Entries beyond len are never driven. step_idx holds 0 when not BUSY.

Test Plan:
1. Reset/table load: rst 2 cycles -> all outputs 0, BUSY=0. Write word[0]=18'h20010, word[1]=18'h00021, word[2]=18'h3FFFF; prog_len=3, Mode=0, pulse Start -> outputs show those three words in cycles N+1..N+3 with step_idx 0,1,2. DONE=1 in N+4 only. Outputs 0 afterwards.
2. Single-step: same table, Mode=1. Start, then hold Step low for 5 cycles -> word[0] held for all 5. Pulse Step twice -> word[1], then word[2]. Third Step -> DONE pulse, IDLE.
3. Abort mid-run: prog_len=16, Abort at step 4 -> next cycle outputs 0, ABORTED=1 for one cycle, DONE never asserts. A new Start then restarts from word[0].
4. Boundaries: prog_len=0 -> DONE one cycle after Start, no LR bit ever set. prog_len=17 with DEPTH=16 -> exactly 16 words driven, step_idx wraps no further than 15.
5. Conflicts: prog_we to addr 1 during RUN -> entry unchanged on the next run. Start+prog_we(addr0) in the same cycle -> new word[0] driven. Start during RUN -> ignored. Start+Abort in IDLE -> stays IDLE.
6. Reset mid-run: rst asserted at step 2 -> next cycle all outputs 0, no DONE/ABORTED, table reads back as 0 on the next run.
